main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm.sv | 181 ++++++++++++++++++
 tb/tb_main_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// Multicycle RV32 control unit (lw, sw, R-type, I-type ALU, jal, beq).
// Moore-decoded datapath controls; pc_write also depends on the ALU zero flag in BEQ.
module main_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       retire,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic pc_update;
  logic branch;
  logic mem_write_dec;
  logic ir_write_dec;
  logic reg_write_dec;
  logic retire_dec;
  logic illegal_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE: state_next = S_MEMADR;
          OP_RTYPE: state_next = S_EXECR;
          OP_ITYPE: state_next = S_EXECI;
          OP_JAL:   state_next = S_JAL;
          OP_BEQ:   state_next = S_BEQ;
          default:  state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_dec = 1'b0;
    ir_write_dec  = 1'b0;
    reg_write_dec = 1'b0;
    retire_dec    = 1'b0;
    illegal_dec   = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_reg)
      S_FETCH: begin
        ir_write_dec = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        // Precompute PC+imm for jal/beq while the register file is read.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: illegal_dec = 1'b0;
          default: illegal_dec = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_dec = 1'b1;
        retire_dec    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_dec = 1'b1;
        retire_dec    = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        result_src    = 2'b00;
        reg_write_dec = 1'b1;
        retire_dec    = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_update  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        branch     = 1'b1;
        retire_dec = 1'b1;
      end
      default: begin
        result_src = 2'b00;
      end
    endcase
  end

  // Reset already forces FETCH selects; enables and pulses are masked so nothing commits.
  assign pc_write   = rst_n & (pc_update | (branch & zero));
  assign mem_write  = rst_n & mem_write_dec;
  assign ir_write   = rst_n & ir_write_dec;
  assign reg_write  = rst_n & reg_write_dec;
  assign retire     = rst_n & retire_dec;
  assign illegal_op = rst_n & illegal_dec;
  assign state      = state_reg;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: per-cycle expected control vectors are queued as
// stimulus is driven and compared against the DUT shortly after each falling edge.
module tb_main_fsm;
  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  main_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .illegal_op(illegal_op), .retire(retire), .state(state)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // {state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal_op, retire}
  localparam logic [18:0] RESET_VEC = {4'd0, 4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};

  typedef struct {
    logic [18:0] exp;
    string       tag;
  } ent_t;

  ent_t sb[$];
  int   checks;
  int   errors;
  logic mon_run;

  always #5 clk = ~clk;

  function automatic logic [18:0] actual_vec();
    return {state, pc_write, adr_src, mem_write, ir_write, result_src,
            alu_src_a, alu_src_b, alu_op, reg_write, illegal_op, retire};
  endfunction

  function automatic logic [18:0] model(input int st, input logic [6:0] o, input logic z);
    logic       pcw, adr, mw, irw, rw, ill, ret;
    logic [1:0] rs, a, b, aop;
    logic [3:0] s4;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; ret = 0;
    rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
    s4 = st[3:0];
    case (st)
      0:  begin adr = 0; irw = 1; a = 2'b00; b = 2'b10; aop = 2'b00; rs = 2'b10; pcw = 1; end
      1:  begin a = 2'b01; b = 2'b01; ill = !(o inside {LW, SW, RT, IT, JL, BQ}); end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin adr = 1; rs = 2'b00; end
      4:  begin rs = 2'b01; rw = 1; ret = 1; end
      5:  begin adr = 1; mw = 1; ret = 1; end
      6:  begin a = 2'b10; b = 2'b00; aop = 2'b10; end
      7:  begin rs = 2'b00; rw = 1; ret = 1; end
      8:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; rs = 2'b00; pcw = 1; end
      10: begin a = 2'b10; b = 2'b00; aop = 2'b01; rs = 2'b00; ret = 1; pcw = z; end
      default: ;
    endcase
    return {s4, pcw, adr, mw, irw, rs, a, b, aop, rw, ill, ret};
  endfunction

  // Drives one instruction cycle by cycle, queueing the expected vector for each cycle.
  task automatic issue(input logic [6:0] o, input logic z, input string name, input int ncyc);
    int seq[$];
    int n;
    case (o)
      LW:      seq = '{0, 1, 2, 3, 4};
      SW:      seq = '{0, 1, 2, 5};
      RT:      seq = '{0, 1, 6, 7};
      IT:      seq = '{0, 1, 8, 7};
      JL:      seq = '{0, 1, 9, 7};
      BQ:      seq = '{0, 1, 10};
      default: seq = '{0, 1};
    endcase
    n = (ncyc > 0 && ncyc < seq.size()) ? ncyc : seq.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op   = o;
      zero = z;
      sb.push_back('{exp: model(seq[i], o, z), tag: $sformatf("%s_c%0d", name, i + 1)});
    end
    #2;
    $display("txn %s op=%b zero=%b cycles=%0d checks=%0d errors=%0d", name, o, z, n, checks, errors);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (actual_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", actual_vec(), RESET_VEC);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (actual_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_held got=%h want=%h", actual_vec(), RESET_VEC);
    end
    rst_n = 1'b1;
    $display("txn reset checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_lw();
    issue(LW, 1'b1, "lw", 0);
  endtask

  task automatic test_sw();
    issue(SW, 1'b0, "sw", 0);
  endtask

  task automatic test_beq();
    issue(BQ, 1'b1, "beq_taken", 0);
    issue(BQ, 1'b0, "beq_not_taken", 0);
  endtask

  task automatic test_back_to_back();
    int pcw_cnt;
    pcw_cnt = 0;
    fork
      begin
        issue(RT, 1'b0, "rtype", 0);
        issue(JL, 1'b0, "jal", 0);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          #1;
          if (pc_write === 1'b1) pcw_cnt++;
        end
      end
    join
    checks++;
    if (pcw_cnt !== 3) begin
      errors++;
      $display("FAIL b2b_pc_write_count got=%0d want=3", pcw_cnt);
    end
  endtask

  task automatic test_illegal();
    issue(BAD, 1'b1, "illegal", 0);
    issue(IT, 1'b0, "itype_after_illegal", 0);
  endtask

  task automatic test_reset_mid();
    issue(LW, 1'b0, "lw_abort", 4);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (actual_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_mid got=%h want=%h", actual_vec(), RESET_VEC);
    end
    @(posedge clk);
    #2;
    checks++;
    if (actual_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_mid_edge got=%h want=%h", actual_vec(), RESET_VEC);
    end
    rst_n = 1'b1;
    issue(SW, 1'b0, "sw_after_abort", 0);
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b1;
    op      = 7'd0;
    zero    = 1'b0;
    checks  = 0;
    errors  = 0;
    mon_run = 1'b1;

    // Scoreboard consumer lives in this process tree so the counters have a single owner.
    fork
      while (mon_run) begin
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
          ent_t e;
          e = sb.pop_front();
          checks++;
          if (actual_vec() !== e.exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", e.tag, actual_vec(), e.exp);
          end
          checks++;
          if ($countones({reg_write, mem_write, ir_write}) > 1) begin
            errors++;
            $display("FAIL %s_enables_onehot got=%b%b%b want=at_most_one", e.tag,
                     reg_write, mem_write, ir_write);
          end
        end
      end
    join_none

    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid();

    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    mon_run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
